// File: rtl/serial_add_dispatcher_pkg.sv
// Shared types and defaults for the serial adder dispatcher.
// Optional watchdog in the top is enabled with DISPATCH_TIMEOUT_EN.
package serial_add_pkg;

   localparam int unsigned OPW         = 8;
   localparam int unsigned DEF_DEPTH   = 4;
   localparam int unsigned DEF_TIMEOUT = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2
   } disp_state_t;

   typedef struct packed {
      logic [OPW-1:0] a;
      logic [OPW-1:0] b;
   } operand_pair_t;

endpackage

// File: rtl/serial_add_dispatcher_fifo.sv
// Operand FIFO: registered storage, combinational head read, occupancy level.
module operand_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       i_push,
   input  logic [W-1:0]               i_wdata,
   input  logic                       i_pop,
   output logic [W-1:0]               o_rdata,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_level == LW'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers are AW bits wide, so wrap modulo DEPTH is implicit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/serial_add_dispatcher.sv
// Feeds operand pairs from a FIFO to the 8-bit serial adder, one at a time.
// Define DISPATCH_TIMEOUT_EN to add the WAIT watchdog and timeout_err port.
module serial_add_dispatcher
   import serial_add_pkg::*;
#(
   parameter int unsigned DEPTH   = DEF_DEPTH,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [OPW-1:0]         in_a,
   input  logic [OPW-1:0]         in_b,
   output logic                   add_load,
   output logic [OPW-1:0]         add_a,
   output logic [OPW-1:0]         add_b,
   input  logic                   add_done,
   output logic                   op_done,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] level,
`ifdef DISPATCH_TIMEOUT_EN
   output logic                   timeout_err,
`endif
   output logic [15:0]            op_count
);

   disp_state_t   r_state;
   logic          r_add_load;
   logic [OPW-1:0] r_add_a;
   logic [OPW-1:0] r_add_b;
   logic          r_op_done;
   logic          r_busy;
   logic [15:0]   r_op_count;

   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   operand_pair_t w_head;
   operand_pair_t w_wdata;

`ifdef DISPATCH_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] r_wait_cnt;
   logic          r_timeout_err;
   assign timeout_err = r_timeout_err;
`endif

   assign w_wdata.a = in_a;
   assign w_wdata.b = in_b;
   assign in_ready  = !w_full;
   assign w_pop     = (r_state == IDLE) && !w_empty;

   operand_fifo #(
      .DEPTH (DEPTH),
      .W     (2 * OPW)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (in_valid),
      .i_wdata (w_wdata),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (level)
   );

   // add_done is checked before the watchdog limit so a late done still succeeds.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_add_load    <= 1'b0;
         r_add_a       <= '0;
         r_add_b       <= '0;
         r_op_done     <= 1'b0;
         r_busy        <= 1'b0;
         r_op_count    <= '0;
`ifdef DISPATCH_TIMEOUT_EN
         r_wait_cnt    <= '0;
         r_timeout_err <= 1'b0;
`endif
      end else begin
         r_add_load <= 1'b0;
         r_op_done  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_add_a    <= w_head.a;
                  r_add_b    <= w_head.b;
                  r_add_load <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= LOAD;
               end
            end
            LOAD: begin
`ifdef DISPATCH_TIMEOUT_EN
               r_wait_cnt <= '0;
`endif
               r_state <= WAIT;
            end
            WAIT: begin
               if (add_done) begin
                  r_op_done  <= 1'b1;
                  r_op_count <= r_op_count + 16'd1;
                  r_busy     <= 1'b0;
                  r_state    <= IDLE;
               end
`ifdef DISPATCH_TIMEOUT_EN
               else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
                  r_timeout_err <= 1'b1;
                  r_busy        <= 1'b0;
                  r_state       <= IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + TW'(1);
               end
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign add_load = r_add_load;
   assign add_a    = r_add_a;
   assign add_b    = r_add_b;
   assign op_done  = r_op_done;
   assign busy     = r_busy;
   assign op_count = r_op_count;

endmodule
